cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Responder on the cache's physical-memory port.
- Accepts one 256-bit line read or write request from the cache controller (pmem_read/pmem_write, held until pmem_resp).
- Converts it into a 4-beat 64-bit burst on the main-memory interface.
- Returns a single-cycle pmem_resp when the burst completes, with the assembled line on reads.

Parameters:
- ADDR_W, 32, byte-address width
- BEAT_W, 64, burst data width per beat
- BEATS, 4, beats per line (power of two)
- LINE_W, BEATS*BEAT_W (256), cache line width
- OFFS_W, log2(LINE_W/8) (5), line-offset bits forced to zero on burst_address

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pmem_address  in  ADDR_W  line address from cache (offset bits ignored)
- pmem_read  in  1  line read request, level, held until pmem_resp
- pmem_write  in  1  line write request, level, held until pmem_resp
- pmem_wdata  in  LINE_W  write line, valid while pmem_write high
- pmem_rdata  out  LINE_W  assembled read line
- pmem_resp  out  1  one-cycle completion pulse
- burst_address  out  ADDR_W  {latched_addr[ADDR_W-1:OFFS_W], OFFS_W'b0}
- burst_read  out  1  held high for the whole read burst
- burst_write  out  1  held high for the whole write burst
- burst_wdata  out  BEAT_W  current write beat
- burst_rdata  in  BEAT_W  read beat, valid when burst_resp high
- burst_resp  in  1  one beat transferred this cycle

Behaviour:
- Reset: clk and rst_n are the only clock and reset; rst_n is asynchronous and active-low. While rst_n is low: state IDLE, beat counter 0, and all outputs 0 (pmem_rdata, burst_address, burst_wdata included).
- Reset mid-burst: immediate abort to IDLE with outputs low. No pmem_resp is generated for the aborted request.
- All outputs are registered or decoded from registered state (Moore); no input-to-output combinational path.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - pmem_write high: latch address and pmem_wdata, go to WRITE.
  - Else pmem_read high: latch address, go to READ.
  - Write has priority if both are high.
  - Counter is cleared on entry to READ/WRITE.
- READ:
  - burst_read=1, burst_address driven.
  - Each cycle with burst_resp=1: burst_rdata is stored into line slice [cnt*BEAT_W +: BEAT_W], counter increments.
  - Beats may have gaps (burst_resp low); the adaptor waits indefinitely.
  - The beat with cnt==BEATS-1 moves the FSM to RESP.
- WRITE:
  - burst_write=1, burst_wdata = latched line slice [cnt*BEAT_W +: BEAT_W].
  - Counter advances on burst_resp; the final beat moves to RESP.
- RESP:
  - pmem_resp=1 for exactly one cycle; burst_read/burst_write=0. Next state is IDLE unconditionally.
  - The request is still high during RESP and must not be re-accepted.
  - A new request present in the following IDLE cycle (e.g. write-back followed by fill) is accepted then.
- Latency:
  - Request sampled at edge N; burst strobe high from cycle N+1.
  - Final beat at edge M; pmem_resp high in cycle M+1.
  - Minimum read/write turnaround = BEATS+2 cycles.
- pmem_rdata is valid in the RESP cycle and holds until the next read beat overwrites it. Writes do not alter pmem_rdata.
- Beat order: beat 0 = line bits [BEAT_W-1:0], ascending.
- burst_resp in IDLE or RESP is ignored (no counter change, no error).
- Counter wraps to 0 after the final beat; it never exceeds BEATS-1.
- Input changes to pmem_address/pmem_wdata after acceptance have no effect until the next acceptance.

Decomposition:
- Shared package cache_types_pkg:
  - adaptor_state_t enum {IDLE, READ, WRITE, RESP}
  - line_t (logic [255:0]) and beat_t (logic [63:0]) typedefs
  - constants BEATS=4, OFFS_W=5
- No sub-module; the beat counter and shift/slice logic stay inline.

Test Plan:
- Reset mid-READ after 2 beats -> all outputs 0 immediately. After release, pmem_resp is never pulsed and a fresh pmem_read is accepted normally.
- Read, pmem_address=0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back:
  - burst_address=0x0000_1220.
  - pmem_resp exactly one cycle, 6 cycles after the request.
  - pmem_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write, line = 256'hDDDD..._CCCC..._BBBB..._AAAA..., with burst_resp gaps of 0-3 random cycles:
  - burst_wdata sequence AAAA.., BBBB.., CCCC.., DDDD..
  - burst_write is held continuously.
  - Single pmem_resp after the 4th beat; pmem_rdata unchanged.
- Write-back then fill (pmem_write, then pmem_read asserted the cycle after pmem_resp):
  - Two distinct bursts.
  - No duplicate write burst from the request still high during RESP.
- Both pmem_read and pmem_write high -> write burst only. Stray burst_resp pulses in IDLE -> counter stays 0 and no outputs change.

Source files
------------

// File: rtl/cache_types_pkg.sv
// cache_types_pkg
//   Shared types and constants for the cache physical-memory side.
//   adaptor_state_t : burst adaptor FSM states
//   line_t / beat_t : one cache line (256 bits) and one burst beat (64 bits)
//   BEATS / OFFS_W  : beats per line and the byte-offset width of a line
package cache_types_pkg;

  localparam int ADDR_W = 32;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int LINE_W = BEATS * BEAT_W;
  localparam int OFFS_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } adaptor_state_t;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Responder on the cache's physical-memory port. One 256-bit line request
//   becomes a 4-beat 64-bit burst on main memory; a single-cycle pmem_resp
//   marks completion, with the assembled line on pmem_rdata for reads.
//
// Ports
//   clk, rst_n       : clock (rising edge) and asynchronous active-low reset
//   pmem_address     : line address from the cache (offset bits ignored)
//   pmem_read/write  : level requests, held by the cache until pmem_resp
//   pmem_wdata       : line to write, sampled when the write is accepted
//   pmem_rdata       : assembled read line, valid in the pmem_resp cycle
//   pmem_resp        : one-cycle completion pulse
//   burst_address    : line-aligned address of the current burst
//   burst_read/write : held high for the whole burst
//   burst_wdata      : current write beat
//   burst_rdata      : read beat, valid with burst_resp
//   burst_resp       : one beat transferred this cycle
//
// Handshake: a cache request is a level that stays high until the cycle
// pmem_resp is 1; it is accepted only in IDLE, so a request still high during
// RESP is not taken twice. On the memory side burst_read/burst_write act as
// valid for the whole burst and burst_resp is a per-beat ready: a beat moves
// on every rising edge where the strobe and burst_resp are both 1, and the
// adaptor waits indefinitely between beats.
//
// Every output is decoded from registered state only, so no input reaches an
// output combinationally.
module cacheline_adaptor
  import cache_types_pkg::*;
#(
  parameter int ADDR_W = cache_types_pkg::ADDR_W,
  parameter int BEAT_W = cache_types_pkg::BEAT_W,
  parameter int BEATS  = cache_types_pkg::BEATS  // power of two, at least 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        pmem_address,
  input  logic                     pmem_read,
  input  logic                     pmem_write,
  input  logic [BEATS*BEAT_W-1:0]  pmem_wdata,
  output logic [BEATS*BEAT_W-1:0]  pmem_rdata,
  output logic                     pmem_resp,
  output logic [ADDR_W-1:0]        burst_address,
  output logic                     burst_read,
  output logic                     burst_write,
  output logic [BEAT_W-1:0]        burst_wdata,
  input  logic [BEAT_W-1:0]        burst_rdata,
  input  logic                     burst_resp
);

  localparam int LINE_W = BEATS * BEAT_W;
  localparam int OFFS_W = $clog2(LINE_W / 8);
  localparam int CNT_W  = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adaptor_state_t              state_q;
  adaptor_state_t              state_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [ADDR_W-1:OFFS_W]      addr_q;
  logic [LINE_W-1:0]           wline_q;
  logic [LINE_W-1:0]           rline_q;

  logic                        accept;
  logic                        beat_done;
  logic                        last_beat;

  // Byte-offset bits of the request address never reach the burst.
  logic                        unused_offs;
  assign unused_offs = ^pmem_address[OFFS_W-1:0];

  assign accept    = (state_q == IDLE) && (pmem_write || pmem_read);
  assign beat_done = ((state_q == READ) || (state_q == WRITE)) && burst_resp;
  assign last_beat = (cnt_q == LAST_BEAT);

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // Write wins when both are raised: a dirty victim must leave the
        // cache before the fill that replaces it.
        if (pmem_write) begin
          state_d = WRITE;
        end else if (pmem_read) begin
          state_d = READ;
        end
      end
      READ: begin
        if (burst_resp && last_beat) begin
          state_d = RESP;
        end
      end
      WRITE: begin
        if (burst_resp && last_beat) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // Unconditional: the request is still high here and must not be
        // taken again.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Beat counter: held at zero in IDLE so every burst starts at beat 0,
  // and wraps to zero naturally after the final beat.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (beat_done) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Request capture: address and write line are frozen at acceptance so
  // later changes on the cache side do not disturb the burst.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wline_q <= '0;
    end else if (accept) begin
      addr_q <= pmem_address[ADDR_W-1:OFFS_W];
      if (pmem_write) begin
        wline_q <= pmem_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read line assembly: beat n lands in bits [n*BEAT_W +: BEAT_W]. Only
  // read beats write here, so a write burst leaves the last read line intact.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rline_q <= '0;
    end else if ((state_q == READ) && burst_resp) begin
      rline_q[cnt_q*BEAT_W +: BEAT_W] <= burst_rdata;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs (Moore)
  // ---------------------------------------------------------------------
  always_comb begin
    pmem_resp     = (state_q == RESP);
    burst_read    = (state_q == READ);
    burst_write   = (state_q == WRITE);
    burst_address = {addr_q, {OFFS_W{1'b0}}};
    pmem_rdata    = rline_q;
    burst_wdata   = '0;
    if (state_q == WRITE) begin
      burst_wdata = wline_q[cnt_q*BEAT_W +: BEAT_W];
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor
//   Directed bench for cacheline_adaptor. Inputs change on the falling edge,
//   outputs are sampled on the falling edge, the DUT acts on the rising edge.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst_n;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int errors;
  int checks;

  cacheline_adaptor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pmem_address  (pmem_address),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_rdata"}, pmem_rdata, '0);
    chk({tag, "_resp"}, {255'b0, pmem_resp}, '0);
    chk({tag, "_baddr"}, {224'b0, burst_address}, '0);
    chk({tag, "_bread"}, {255'b0, burst_read}, '0);
    chk({tag, "_bwrite"}, {255'b0, burst_write}, '0);
    chk({tag, "_bwdata"}, {192'b0, burst_wdata}, '0);
  endtask

  // Serve a read burst back-to-back from beats[] until pmem_resp (bounded).
  // Returns the number of falling edges from the request cycle to pmem_resp.
  task automatic serve_read(input logic [63:0] beats[4], output int lat);
    int b;
    b = 0;
    lat = 0;
    while (!pmem_resp && lat < 40) begin
      if (burst_read && b < 4) begin
        burst_rdata = beats[b];
        burst_resp  = 1'b1;
        b++;
      end else begin
        burst_rdata = '0;
        burst_resp  = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    burst_resp  = 1'b0;
    burst_rdata = '0;
  endtask

  logic [63:0]  rbeats[4];
  logic [63:0]  fbeats[4];
  logic [63:0]  xbeats[4];
  logic [63:0]  wbeats[4];
  logic [255:0] rline;
  logic [255:0] fline;
  logic [255:0] wline;
  logic [255:0] bline;
  logic [255:0] xline;
  int           lat;
  int           gap;
  int           pulses;

  initial begin
    errors = 0;
    checks = 0;

    rbeats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    rline  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wbeats = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
               64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    wline  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    fbeats = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
    fline  = {64'h0F0F_F0F0_0F0F_F0F0, 64'h5555_AAAA_5555_AAAA,
              64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    bline  = {64'h4040_4040_4040_4040, 64'h3030_3030_3030_3030,
              64'h2020_2020_2020_2020, 64'h1010_1010_1010_1010};
    xbeats = '{64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0002,
               64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0004};
    xline  = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
              64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};

    // ---------------- reset ----------------
    rst_n        = 1'b0;
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    burst_rdata  = '0;
    burst_resp   = 1'b0;
    #1;
    outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cnt", {254'b0, dut.cnt_q}, '0);

    // ---------------- read 0x1234 back-to-back ----------------
    pmem_address = 32'h0000_1234;
    pmem_read    = 1'b1;
    serve_read(rbeats, lat);
    chk("rd_latency", lat, 5);
    chk("rd_resp", {255'b0, pmem_resp}, 256'd1);
    chk("rd_addr", {224'b0, burst_address}, 256'h0000_1220);
    chk("rd_line", pmem_rdata, rline);
    chk("rd_bread_resp", {255'b0, burst_read}, '0);
    pmem_read = 1'b0;
    @(negedge clk);
    chk("rd_resp_one", {255'b0, pmem_resp}, '0);
    chk("rd_cnt_wrap", {254'b0, dut.cnt_q}, '0);
    chk("rd_line_hold", pmem_rdata, rline);

    // ---------------- write with random gaps, then fill ----------------
    pmem_address = 32'hABCD_EF7F;
    pmem_wdata   = wline;
    pmem_write   = 1'b1;
    @(negedge clk);
    // Late changes on the cache side must not leak into the burst.
    pmem_address = 32'hFFFF_FFFF;
    pmem_wdata   = '1;
    chk("wr_addr", {224'b0, burst_address}, 256'hABCD_EF60);
    for (int b = 0; b < 4; b++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        chk("wr_hold", {255'b0, burst_write}, 256'd1);
        chk("wr_wdata_gap", {192'b0, burst_wdata}, {192'b0, wbeats[b]});
        burst_resp = 1'b0;
        @(negedge clk);
      end
      chk("wr_hold", {255'b0, burst_write}, 256'd1);
      chk("wr_no_read", {255'b0, burst_read}, '0);
      chk("wr_wdata", {192'b0, burst_wdata}, {192'b0, wbeats[b]});
      burst_resp = 1'b1;
      @(negedge clk);
    end
    burst_resp = 1'b0;
    chk("wr_resp", {255'b0, pmem_resp}, 256'd1);
    chk("wr_bwrite_resp", {255'b0, burst_write}, '0);
    chk("wr_rdata_kept", pmem_rdata, rline);
    // pmem_write stays high through RESP; it must not start a second burst.
    @(negedge clk);
    chk("wb_idle_bwrite", {255'b0, burst_write}, '0);
    chk("wb_idle_bread", {255'b0, burst_read}, '0);
    chk("wb_idle_resp", {255'b0, pmem_resp}, '0);
    pmem_write   = 1'b0;
    pmem_read    = 1'b1;
    pmem_address = 32'h2000_0040;
    @(negedge clk);
    chk("fill_bread", {255'b0, burst_read}, 256'd1);
    chk("fill_no_write", {255'b0, burst_write}, '0);
    chk("fill_addr", {224'b0, burst_address}, 256'h2000_0040);
    serve_read(fbeats, lat);
    chk("fill_latency", lat, 4);
    chk("fill_resp", {255'b0, pmem_resp}, 256'd1);
    chk("fill_line", pmem_rdata, fline);
    pmem_read = 1'b0;
    @(negedge clk);

    // ---------------- read and write together: write only ----------------
    pmem_address = 32'h0000_8000;
    pmem_wdata   = bline;
    pmem_read    = 1'b1;
    pmem_write   = 1'b1;
    @(negedge clk);
    chk("both_bwrite", {255'b0, burst_write}, 256'd1);
    chk("both_no_read", {255'b0, burst_read}, '0);
    for (int b = 0; b < 4; b++) begin
      chk("both_wdata", {192'b0, burst_wdata}, {192'b0, bline[b*64 +: 64]});
      burst_resp = 1'b1;
      @(negedge clk);
    end
    burst_resp = 1'b0;
    chk("both_resp", {255'b0, pmem_resp}, 256'd1);
    chk("both_rdata_kept", pmem_rdata, fline);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    @(negedge clk);

    // ---------------- stray burst_resp in IDLE ----------------
    burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    burst_resp  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_cnt", {254'b0, dut.cnt_q}, '0);
      chk("stray_resp", {255'b0, pmem_resp}, '0);
      chk("stray_bread", {255'b0, burst_read}, '0);
      chk("stray_bwrite", {255'b0, burst_write}, '0);
      chk("stray_bwdata", {192'b0, burst_wdata}, '0);
      chk("stray_rdata", pmem_rdata, fline);
      chk("stray_addr", {224'b0, burst_address}, 256'h0000_8000);
    end
    burst_resp  = 1'b0;
    burst_rdata = '0;

    // ---------------- reset in the middle of a read ----------------
    pmem_address = 32'h0000_4444;
    pmem_read    = 1'b1;
    @(negedge clk);
    chk("abort_bread", {255'b0, burst_read}, 256'd1);
    for (int b = 0; b < 2; b++) begin
      burst_rdata = rbeats[b];
      burst_resp  = 1'b1;
      @(negedge clk);
    end
    burst_resp = 1'b0;
    rst_n      = 1'b0;
    #1;
    outputs_zero("abort");
    chk("abort_cnt", {254'b0, dut.cnt_q}, '0);
    @(negedge clk);
    rst_n     = 1'b1;
    pmem_read = 1'b0;
    pulses    = 0;
    repeat (6) begin
      @(negedge clk);
      if (pmem_resp) pulses++;
    end
    chk("abort_no_resp", pulses, 0);
    pmem_address = 32'h0000_4444;
    pmem_read    = 1'b1;
    serve_read(xbeats, lat);
    chk("after_abort_latency", lat, 5);
    chk("after_abort_resp", {255'b0, pmem_resp}, 256'd1);
    chk("after_abort_line", pmem_rdata, xline);
    chk("after_abort_addr", {224'b0, burst_address}, 256'h0000_4440);
    pmem_read = 1'b0;
    @(negedge clk);
    chk("after_abort_idle", {255'b0, pmem_resp}, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
